// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: N-way arbiter with a registered one-hot grant.
// It runs fixed-priority (bit 0 highest) or round-robin arbitration and can
// optionally limit how long one owner holds the grant while others wait.
module rr_priority_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int IDXW     = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            mode,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [IDXW-1:0] grant_idx
);

   // The hold counter only has to reach MAX_HOLD. When tenure is unlimited,
   // a 1-bit counter that stays saturated at 1 is enough.
   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CW{1'b1}} : CW'(MAX_HOLD);
   localparam bit PREEMPT_EN = (MAX_HOLD != 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]   hold_q, hold_d;

   logic            do_grant;
   logic [N-1:0]    cand;
   logic [N-1:0]    others;
   logic [IDXW-1:0] win;

   // Return the first set bit of mask. The search starts at start and
   // wraps from N-1 back to 0.
   function automatic logic [IDXW-1:0] pick(input logic [N-1:0] mask,
                                            input logic [IDXW-1:0] start);
      logic [IDXW-1:0] res;
      logic [IDXW-1:0] pos;
      logic            found;
      res   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         pos = IDXW'((int'(start) + i) % N);
         if (!found && mask[pos]) begin
            res   = pos;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Next-state decision: keep the owner, hand over directly, or go idle.
   always_comb begin
      // NOTE: every variable gets a default first so that no path can infer a latch.
      state_d  = state_q;
      grant_d  = grant_q;
      idx_d    = idx_q;
      ptr_d    = ptr_q;
      hold_d   = hold_q;
      do_grant = 1'b0;
      cand     = '0;
      others   = req & ~grant_q;
      win      = '0;

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               do_grant = 1'b1;
               cand     = req;
            end
         end
         BUSY: begin
            if (req[idx_q] && !(PREEMPT_EN && (hold_q == HOLD_SAT) && (|others))) begin
               // The owner keeps the grant. The tenure count saturates.
               if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
            end else if (|others) begin
               // The owner released or was preempted. The owner is excluded from the pick.
               do_grant = 1'b1;
               cand     = others;
            end else begin
               state_d = IDLE;
               grant_d = '0;
               idx_d   = '0;
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_grant) begin
         // mode is sampled only here, so it never changes a grant that is already held.
         win     = pick(cand, mode ? ptr_q : '0);
         grant_d = {{(N-1){1'b0}}, 1'b1} << win;
         idx_d   = win;
         state_d = BUSY;
         hold_d  = CW'(1);
         if (mode) ptr_d = IDXW'((int'(win) + 1) % N);
      end
   end

   // State register. Reset is asynchronous, so grant drops as soon as rst_n goes low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so that all registers update together.
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter with N=4 and MAX_HOLD=4.
// Each step queues its expected grant. The entry is popped and compared
// after the clock edge, when the DUT has produced its output.
module tb_rr_priority_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic         mode;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [1:0]   grant_idx;

   int checks = 0;
   int errors = 0;
   int step_no = 0;
   logic [N-1:0] exp_q[$];

   rr_priority_arbiter #(.N(N), .MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .mode        (mode),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] idx_of(input logic [N-1:0] g);
      logic [31:0] r;
      r = 0;
      for (int i = 0; i < N; i++) if (g[i]) r = i;
      return r;
   endfunction

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic compare();
      logic [N-1:0] e;
      string t;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = exp_q.pop_front();
         t = $sformatf("step%0d", step_no);
         check({t, "_grant"}, 32'(grant), 32'(e));
         check({t, "_valid"}, 32'(grant_valid), 32'(|e));
         check({t, "_idx"}, 32'(grant_idx), idx_of(e));
      end
   endtask

   // Drive one cycle of stimulus, queue its expected grant, and compare after the edge.
   task automatic step(input logic [N-1:0] r, input logic m, input logic [N-1:0] exp_g);
      req  = r;
      mode = m;
      exp_q.push_back(exp_g);
      step_no++;
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      req   = '0;
      mode  = 1'b0;

      // Outputs while reset is held.
      #12;
      check("reset_grant", 32'(grant), 0);
      check("reset_valid", 32'(grant_valid), 0);
      check("reset_idx", 32'(grant_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // No grant appears while req stays zero after release.
      step(4'b0000, 1'b0, 4'b0000);
      // Fixed priority: the lowest set bit wins.
      step(4'b1010, 1'b0, 4'b0010);
      step(4'b1010, 1'b0, 4'b0010);
      // A mode change does not disturb the held grant.
      step(4'b1010, 1'b1, 4'b0010);
      // The owner drops its request. Bit 3 gets the grant with no idle bubble, and ptr wraps to 0.
      step(4'b1000, 1'b1, 4'b1000);
      // Everything drops, so the arbiter goes idle.
      step(4'b0000, 1'b1, 4'b0000);
      step(4'b0000, 1'b1, 4'b0000);
      // ptr has wrapped to 0, so 1001 grants bit 0.
      step(4'b1001, 1'b1, 4'b0001);
      step(4'b0000, 1'b1, 4'b0000);
      // A request arriving later is granted one cycle after it appears.
      step(4'b0100, 1'b1, 4'b0100);
      step(4'b0000, 1'b1, 4'b0000);
      // Set ptr back to 0 with a bit-3 grant.
      step(4'b1000, 1'b1, 4'b1000);
      step(4'b0000, 1'b1, 4'b0000);

      // Round-robin rotation: each owner drops its request for one cycle.
      step(4'b1111, 1'b1, 4'b0001);
      step(4'b1110, 1'b1, 4'b0010);
      step(4'b1101, 1'b1, 4'b0100);
      step(4'b1011, 1'b1, 4'b1000);
      step(4'b0111, 1'b1, 4'b0001);
      step(4'b0000, 1'b1, 4'b0000);
      step(4'b1000, 1'b1, 4'b1000);
      step(4'b0000, 1'b1, 4'b0000);

      // Tenure limit of 4 cycles with 0011 held high.
      for (int i = 0; i < 4; i++) step(4'b0011, 1'b1, 4'b0001);
      for (int i = 0; i < 4; i++) step(4'b0011, 1'b1, 4'b0010);
      step(4'b0011, 1'b1, 4'b0001);
      // At the tenure limit with no competitor, the owner keeps the grant.
      for (int i = 0; i < 5; i++) step(4'b0001, 1'b1, 4'b0001);
      // Fixed-mode preemption hands over to the best requester other than the owner.
      step(4'b0011, 1'b0, 4'b0010);
      for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, 4'b0010);
      step(4'b0011, 1'b0, 4'b0001);
      step(4'b0000, 1'b0, 4'b0000);

      // Leave ptr at 2, then take a fixed-mode grant of bit 3 (ptr holds at 2).
      step(4'b0010, 1'b1, 4'b0010);
      step(4'b0000, 1'b1, 4'b0000);
      step(4'b1000, 1'b0, 4'b1000);

      // Reset pulse between clock edges clears the grant at once.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_grant", 32'(grant), 0);
      check("async_rst_valid", 32'(grant_valid), 0);
      check("async_rst_idx", 32'(grant_idx), 0);
      req = '0;
      @(posedge clk);
      #1;
      check("rst_hold_grant", 32'(grant), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b0000, 1'b1, 4'b0000);
      // ptr is back at 0, so 0110 picks bit 1 (a stale ptr of 2 would pick bit 2).
      step(4'b0110, 1'b1, 4'b0010);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
